// File: rtl/neuron_out_backprop_if.sv
// Operand/result bundle for the output-neuron backprop block.
// Carries both valid/ready handshakes together with their payloads.
interface neuron_out_backprop_if #(
  parameter int unsigned W = 20
);
  logic                in_valid;
  logic                in_ready;
  logic signed [W-1:0] a2_1;
  logic signed [W-1:0] a2_2;
  logic signed [W-1:0] z3;
  logic signed [W-1:0] target;
  logic signed [W-1:0] weight3_1;
  logic signed [W-1:0] weight3_2;
  logic signed [W-1:0] bias3;
  logic signed [W-1:0] lr;
  logic                out_valid;
  logic                out_ready;
  logic signed [W-1:0] weight3_1_new;
  logic signed [W-1:0] weight3_2_new;
  logic signed [W-1:0] bias3_new;
  logic signed [W-1:0] delta3;
  logic signed [W-1:0] da2_1;
  logic signed [W-1:0] da2_2;

  modport master (
    output in_valid, a2_1, a2_2, z3, target, weight3_1, weight3_2, bias3, lr, out_ready,
    input  in_ready, out_valid, weight3_1_new, weight3_2_new, bias3_new, delta3, da2_1, da2_2
  );

  modport slave (
    input  in_valid, a2_1, a2_2, z3, target, weight3_1, weight3_2, bias3, lr, out_ready,
    output in_ready, out_valid, weight3_1_new, weight3_2_new, bias3_new, delta3, da2_1, da2_2
  );
endinterface

// File: rtl/neuron_out_backprop.sv
// Output-neuron backward pass: error, weight/bias update and hidden-layer error
// propagation, sequenced over one shared signed multiplier.
module neuron_out_backprop #(
  parameter int unsigned W    = 20,
  parameter int unsigned FRAC = 15
) (
  input logic                  clk,
  input logic                  rst_n,
  neuron_out_backprop_if.slave bus
);
  localparam int unsigned PW = 2 * W;

  typedef enum logic [3:0] {
    IDLE, ERR, GRAD, UPD_W1, UPD_W2, UPD_B, PROP1, PROP2, DONE
  } state_t;

  state_t state, state_nx;
  logic   accept_c, handoff_c;
  logic   in_ready_q, out_valid_q;

  logic signed [W-1:0]  a1_q, a2_q, z3_q, tgt_q, w1_q, w2_q, b_q, lr_q, g_q;
  logic signed [W-1:0]  d3_q, w1n_q, w2n_q, bn_q, da1_q, da2_q;
  logic signed [W-1:0]  mul_a_c, mul_b_c, prod_sat_c;
  logic signed [PW-1:0] prod_c, prod_sh_c;

  // Clamp a W+1-bit sum/difference into W bits.
  function automatic logic signed [W-1:0] sat_sum(input logic signed [W:0] x);
    if (x[W] != x[W-1]) return x[W] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
    return x[W-1:0];
  endfunction

  // Clamp a shifted full-width product into W bits.
  function automatic logic signed [W-1:0] sat_prod(input logic signed [PW-1:0] x);
    if ((&x[PW-1:W-1]) || !(|x[PW-1:W-1])) return x[W-1:0];
    return x[PW-1] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
  endfunction

  function automatic logic signed [W-1:0] sub_sat(input logic signed [W-1:0] a,
                                                  input logic signed [W-1:0] b);
    return sat_sum($signed({a[W-1], a}) - $signed({b[W-1], b}));
  endfunction

  // Next-state and handshake decode.
  always_comb begin
    state_nx  = state;
    accept_c  = 1'b0;
    handoff_c = 1'b0;
    case (state)
      IDLE: if (bus.in_valid) begin
        accept_c = 1'b1;
        state_nx = ERR;
      end
      ERR:    state_nx = GRAD;
      GRAD:   state_nx = UPD_W1;
      UPD_W1: state_nx = UPD_W2;
      UPD_W2: state_nx = UPD_B;
      UPD_B:  state_nx = PROP1;
      PROP1:  state_nx = PROP2;
      PROP2:  state_nx = DONE;
      DONE: if (out_valid_q && bus.out_ready) begin
        handoff_c = 1'b1;
        state_nx  = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  // Shared multiplier operand select.
  always_comb begin
    mul_a_c = d3_q;
    mul_b_c = w1_q;
    case (state)
      GRAD:    begin mul_a_c = lr_q; mul_b_c = d3_q; end
      UPD_W1:  begin mul_a_c = g_q;  mul_b_c = a1_q; end
      UPD_W2:  begin mul_a_c = g_q;  mul_b_c = a2_q; end
      PROP2:   begin mul_a_c = d3_q; mul_b_c = w2_q; end
      default: ;
    endcase
  end

  assign prod_c     = PW'(mul_a_c) * PW'(mul_b_c);
  assign prod_sh_c  = prod_c >>> FRAC;
  assign prod_sat_c = sat_prod(prod_sh_c);

  // Handshake flags; out_valid follows one edge after DONE is entered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      in_ready_q  <= (state_nx == IDLE);
      out_valid_q <= (state == DONE) && !handoff_c;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a1_q  <= '0; a2_q  <= '0; z3_q  <= '0; tgt_q <= '0;
      w1_q  <= '0; w2_q  <= '0; b_q   <= '0; lr_q  <= '0;
      g_q   <= '0; d3_q  <= '0; w1n_q <= '0; w2n_q <= '0;
      bn_q  <= '0; da1_q <= '0; da2_q <= '0;
    end else begin
      if (accept_c) begin
        a1_q  <= bus.a2_1;      a2_q <= bus.a2_2;
        z3_q  <= bus.z3;        tgt_q <= bus.target;
        w1_q  <= bus.weight3_1; w2_q <= bus.weight3_2;
        b_q   <= bus.bias3;     lr_q <= bus.lr;
      end
      case (state)
        ERR:     d3_q  <= sub_sat(z3_q, tgt_q);
        GRAD:    g_q   <= prod_sat_c;
        UPD_W1:  w1n_q <= sub_sat(w1_q, prod_sat_c);
        UPD_W2:  w2n_q <= sub_sat(w2_q, prod_sat_c);
        UPD_B:   bn_q  <= sub_sat(b_q, g_q);
        PROP1:   da1_q <= prod_sat_c;
        PROP2:   da2_q <= prod_sat_c;
        default: ;
      endcase
    end
  end

  assign bus.in_ready      = in_ready_q;
  assign bus.out_valid     = out_valid_q;
  assign bus.delta3        = d3_q;
  assign bus.weight3_1_new = w1n_q;
  assign bus.weight3_2_new = w2n_q;
  assign bus.bias3_new     = bn_q;
  assign bus.da2_1         = da1_q;
  assign bus.da2_2         = da2_q;
endmodule
